// File: rtl/id_stage.sv
// Instruction-decode stage with the ID/EX pipeline register.
// Reads the register file (with same-cycle writeback forwarding), decodes
// control for the supported MIPS subset, sign-extends the immediate, and
// handles load-use stalls (one bubble plus fetch hold) and branch flushes.
// The instruction field layout is fixed by the ISA, so RA_W is expected to be 5.
module id_stage #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instr_in,
  input  logic              instr_valid,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [RA_W-1:0]   wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] rs,
  output logic [DATA_W-1:0] rt,
  output logic [DATA_W-1:0] sign_ext,
  output logic              ALUSrc,
  output logic [1:0]        ALUOp,
  output logic              branch,
  output logic              mem_read,
  output logic              mem_write,
  output logic              reg_write,
  output logic [RA_W-1:0]   dest_reg,
  output logic              stall_flag_ex,
  output logic              hold_fetch,
  output logic              illegal_instr
);

  localparam int NUM_REGS = 1 << RA_W;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;

  localparam logic [5:0] FN_ADD  = 6'b000000;
  localparam logic [5:0] FN_MUL  = 6'b000001;
  localparam logic [5:0] FN_SUB  = 6'b000010;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_BEQ = 2'b01;
  localparam logic [1:0] ALU_R   = 2'b10;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_STALL = 1'b1;

  localparam logic [RA_W-1:0]   REG_ZERO  = {RA_W{1'b0}};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  // Register file storage; entry 0 is never written so it stays zero.
  logic [DATA_W-1:0] regs_r [NUM_REGS];

  logic [0:0]        state_r;
  logic [0:0]        state_nxt_s;

  // Instruction fields
  logic [5:0]        opcode_s;
  logic [5:0]        funct_s;
  logic [RA_W-1:0]   rs_addr_s;
  logic [RA_W-1:0]   rt_addr_s;
  logic [RA_W-1:0]   rd_addr_s;
  logic [15:0]       imm_s;
  logic [DATA_W-1:0] sign_ext_s;

  // Operand reads after forwarding
  logic [DATA_W-1:0] rs_val_s;
  logic [DATA_W-1:0] rt_val_s;

  // Decoded control
  logic              dec_alusrc_s;
  logic [1:0]        dec_aluop_s;
  logic              dec_branch_s;
  logic              dec_mem_read_s;
  logic              dec_mem_write_s;
  logic              dec_reg_write_s;
  logic [RA_W-1:0]   dec_dest_s;
  logic              dec_legal_s;
  logic              dec_uses_rt_s;

  // Pipeline control
  logic              hazard_s;
  logic              bubble_s;
  logic              illegal_set_s;

  assign opcode_s   = instr_in[31:26];
  assign rs_addr_s  = instr_in[25:21];
  assign rt_addr_s  = instr_in[20:16];
  assign rd_addr_s  = instr_in[15:11];
  assign imm_s      = instr_in[15:0];
  assign funct_s    = instr_in[5:0];
  assign sign_ext_s = {{(DATA_W-16){imm_s[15]}}, imm_s};

  // Register file write port; r0 writes are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= DATA_ZERO;
      end
    end else if (wb_en && (wb_addr != REG_ZERO)) begin
      regs_r[wb_addr] <= wb_data;
    end
  end

  // rs read port: r0 reads zero, a same-cycle writeback is forwarded.
  always_comb begin
    rs_val_s = DATA_ZERO;
    if (rs_addr_s == REG_ZERO) begin
      rs_val_s = DATA_ZERO;
    end else if (wb_en && (wb_addr == rs_addr_s)) begin
      rs_val_s = wb_data;
    end else begin
      rs_val_s = regs_r[rs_addr_s];
    end
  end

  // rt read port: r0 reads zero, a same-cycle writeback is forwarded.
  always_comb begin
    rt_val_s = DATA_ZERO;
    if (rt_addr_s == REG_ZERO) begin
      rt_val_s = DATA_ZERO;
    end else if (wb_en && (wb_addr == rt_addr_s)) begin
      rt_val_s = wb_data;
    end else begin
      rt_val_s = regs_r[rt_addr_s];
    end
  end

  // Control decode; dec_uses_rt_s marks instructions that read rt as a source.
  always_comb begin
    dec_alusrc_s    = 1'b0;
    dec_aluop_s     = ALU_ADD;
    dec_branch_s    = 1'b0;
    dec_mem_read_s  = 1'b0;
    dec_mem_write_s = 1'b0;
    dec_reg_write_s = 1'b0;
    dec_dest_s      = REG_ZERO;
    dec_legal_s     = 1'b0;
    dec_uses_rt_s   = 1'b0;
    case (opcode_s)
      OP_R: begin
        dec_uses_rt_s = 1'b1;
        case (funct_s)
          FN_ADD, FN_MUL, FN_SUB: begin
            dec_legal_s     = 1'b1;
            dec_aluop_s     = ALU_R;
            dec_reg_write_s = 1'b1;
            dec_dest_s      = rd_addr_s;
          end
          default: begin
            dec_legal_s = 1'b0;
          end
        endcase
      end
      OP_LW: begin
        dec_legal_s     = 1'b1;
        dec_alusrc_s    = 1'b1;
        dec_mem_read_s  = 1'b1;
        dec_reg_write_s = 1'b1;
        dec_dest_s      = rt_addr_s;
      end
      OP_SW: begin
        dec_legal_s     = 1'b1;
        dec_alusrc_s    = 1'b1;
        dec_mem_write_s = 1'b1;
        dec_uses_rt_s   = 1'b1;
      end
      OP_ADDI: begin
        dec_legal_s     = 1'b1;
        dec_alusrc_s    = 1'b1;
        dec_reg_write_s = 1'b1;
        dec_dest_s      = rt_addr_s;
      end
      OP_BEQ: begin
        dec_legal_s   = 1'b1;
        dec_aluop_s   = ALU_BEQ;
        dec_branch_s  = 1'b1;
        dec_uses_rt_s = 1'b1;
      end
      default: begin
        dec_legal_s = 1'b0;
      end
    endcase
  end

  // Load-use hazard: a load in EX produces a register this instruction reads.
  // Skipped in STALL because the bubble already covers the load latency.
  always_comb begin
    hazard_s = 1'b0;
    if ((state_r == ST_RUN) && instr_valid && !flush &&
        mem_read && (dest_reg != REG_ZERO)) begin
      if ((dest_reg == rs_addr_s) ||
          ((dest_reg == rt_addr_s) && dec_uses_rt_s)) begin
        hazard_s = 1'b1;
      end else begin
        hazard_s = 1'b0;
      end
    end else begin
      hazard_s = 1'b0;
    end
  end

  assign bubble_s      = flush | ~instr_valid | ~dec_legal_s | hazard_s;
  assign illegal_set_s = instr_valid & ~flush & ~dec_legal_s;
  assign hold_fetch    = hazard_s & ~reset;

  // Next-state: a hazard parks one cycle in STALL; everything else runs.
  always_comb begin
    state_nxt_s = ST_RUN;
    case (state_r)
      ST_RUN: begin
        if (hazard_s) begin
          state_nxt_s = ST_STALL;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_STALL: begin
        state_nxt_s = ST_RUN;
      end
      default: begin
        state_nxt_s = ST_RUN;
      end
    endcase
  end

  // Stall FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // ID/EX pipeline register: operands always advance, control is zeroed on a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs            <= DATA_ZERO;
      rt            <= DATA_ZERO;
      sign_ext      <= DATA_ZERO;
      ALUSrc        <= 1'b0;
      ALUOp         <= 2'b00;
      branch        <= 1'b0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      reg_write     <= 1'b0;
      dest_reg      <= REG_ZERO;
      stall_flag_ex <= 1'b1;
    end else begin
      rs       <= rs_val_s;
      rt       <= rt_val_s;
      sign_ext <= sign_ext_s;
      if (bubble_s) begin
        ALUSrc        <= 1'b0;
        ALUOp         <= 2'b00;
        branch        <= 1'b0;
        mem_read      <= 1'b0;
        mem_write     <= 1'b0;
        reg_write     <= 1'b0;
        dest_reg      <= REG_ZERO;
        stall_flag_ex <= 1'b1;
      end else begin
        ALUSrc        <= dec_alusrc_s;
        ALUOp         <= dec_aluop_s;
        branch        <= dec_branch_s;
        mem_read      <= dec_mem_read_s;
        mem_write     <= dec_mem_write_s;
        reg_write     <= dec_reg_write_s;
        dest_reg      <= dec_dest_s;
        stall_flag_ex <= 1'b0;
      end
    end
  end

  // Sticky illegal-instruction flag, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_instr <= 1'b0;
    end else if (illegal_set_s) begin
      illegal_instr <= 1'b1;
    end else begin
      illegal_instr <= illegal_instr;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Testbench for id_stage: directed scenarios followed by randomized traffic,
// all checked against a behavioural model of the decode stage.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_in;
  logic        instr_valid;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] rs, rt, sign_ext;
  logic        ALUSrc;
  logic [1:0]  ALUOp;
  logic        branch, mem_read, mem_write, reg_write;
  logic [4:0]  dest_reg;
  logic        stall_flag_ex, hold_fetch, illegal_instr;

  int checks   = 0;
  int failures = 0;

  id_stage dut (
    .clk(clk), .reset(reset), .instr_in(instr_in), .instr_valid(instr_valid),
    .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .rs(rs), .rt(rt), .sign_ext(sign_ext), .ALUSrc(ALUSrc), .ALUOp(ALUOp),
    .branch(branch), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .dest_reg(dest_reg), .stall_flag_ex(stall_flag_ex),
    .hold_fetch(hold_fetch), .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       alusrc;
    logic [1:0] aluop;
    logic       br;
    logic       mr;
    logic       mw;
    logic       rw;
    logic [4:0] dest;
    logic       legal;
    logic       uses_rt;
  } ctl_t;

  typedef struct packed {
    ctl_t        c;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] se;
    logic        stall;
    logic        ill;
  } exp_t;

  // Model state: architectural registers, expected ID/EX contents and
  // whether the previous cycle inserted a load-use bubble.
  logic [31:0] m_regs [32];
  exp_t        m_exp;
  logic        m_stalled;
  logic        m_hz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Instruction meaning from the ISA table.
  function automatic ctl_t decode(input logic [31:0] ins);
    ctl_t c;
    c = '0;
    case (ins[31:26])
      6'b000000: begin
        c.uses_rt = 1'b1;
        if (ins[5:0] <= 6'd2) begin
          c.legal = 1'b1; c.aluop = 2'b10; c.rw = 1'b1; c.dest = ins[15:11];
        end
      end
      6'b100011: begin c.legal = 1'b1; c.alusrc = 1'b1; c.mr = 1'b1; c.rw = 1'b1; c.dest = ins[20:16]; end
      6'b101011: begin c.legal = 1'b1; c.alusrc = 1'b1; c.mw = 1'b1; c.uses_rt = 1'b1; end
      6'b001000: begin c.legal = 1'b1; c.alusrc = 1'b1; c.rw = 1'b1; c.dest = ins[20:16]; end
      6'b000100: begin c.legal = 1'b1; c.aluop = 2'b01; c.br = 1'b1; c.uses_rt = 1'b1; end
      default:   c.legal = 1'b0;
    endcase
    return c;
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a, input logic we,
                                             input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
    if (we && wa == a) return wd;
    return m_regs[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_exp       = '0;
    m_exp.stall = 1'b1;
    m_stalled   = 1'b0;
    m_hz        = 1'b0;
  endtask

  task automatic compare_all(input string pfx);
    check({pfx, ".stall"},   {31'd0, stall_flag_ex}, {31'd0, m_exp.stall});
    check({pfx, ".alusrc"},  {31'd0, ALUSrc},        {31'd0, m_exp.c.alusrc});
    check({pfx, ".aluop"},   {30'd0, ALUOp},         {30'd0, m_exp.c.aluop});
    check({pfx, ".branch"},  {31'd0, branch},        {31'd0, m_exp.c.br});
    check({pfx, ".memrd"},   {31'd0, mem_read},      {31'd0, m_exp.c.mr});
    check({pfx, ".memwr"},   {31'd0, mem_write},     {31'd0, m_exp.c.mw});
    check({pfx, ".regwr"},   {31'd0, reg_write},     {31'd0, m_exp.c.rw});
    check({pfx, ".dest"},    {27'd0, dest_reg},      {27'd0, m_exp.c.dest});
    check({pfx, ".illegal"}, {31'd0, illegal_instr}, {31'd0, m_exp.ill});
    if (!m_exp.stall) begin
      check({pfx, ".rs"},       rs,       m_exp.rs);
      check({pfx, ".rt"},       rt,       m_exp.rt);
      check({pfx, ".sign_ext"}, sign_ext, m_exp.se);
    end
  endtask

  // One decode cycle: drive at the falling edge, check hold_fetch mid-cycle,
  // advance the model, then check ID/EX just after the rising edge.
  task automatic step(input logic [31:0] ins, input logic v, input logic f,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd);
    ctl_t c;
    logic bub;
    instr_in = ins; instr_valid = v; flush = f; wb_en = we; wb_addr = wa; wb_data = wd;
    #1;
    c = decode(ins);
    m_hz = !m_stalled && v && !f && m_exp.c.mr && (m_exp.c.dest != 5'd0) &&
           ((m_exp.c.dest == ins[25:21]) || ((m_exp.c.dest == ins[20:16]) && c.uses_rt));
    check("hold_fetch", {31'd0, hold_fetch}, {31'd0, m_hz});
    bub = f || !v || !c.legal || m_hz;
    m_exp.rs = model_read(ins[25:21], we, wa, wd);
    m_exp.rt = model_read(ins[20:16], we, wa, wd);
    m_exp.se = {{16{ins[15]}}, ins[15:0]};
    if (bub) begin
      m_exp.c = '0; m_exp.stall = 1'b1;
    end else begin
      m_exp.c = c;  m_exp.stall = 1'b0;
    end
    if (v && !f && !c.legal) m_exp.ill = 1'b1;
    if (we && wa != 5'd0) m_regs[wa] = wd;
    m_stalled = m_hz;
    @(posedge clk);
    #1;
    compare_all("idex");
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check("rst.hold_fetch", {31'd0, hold_fetch}, 32'd0);
    check("rst.rs", rs, 32'd0);
    compare_all("rst");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    int sel;
    logic [4:0] a, b, d;
    a = 5'($urandom_range(0, 7));
    b = 5'($urandom_range(0, 7));
    d = 5'($urandom_range(0, 7));
    sel = $urandom_range(0, 99);
    if (sel < 25)      return {6'b100011, a, b, 16'($urandom)};
    else if (sel < 40) return {6'b101011, a, b, 16'($urandom)};
    else if (sel < 55) return {6'b001000, a, b, 16'($urandom)};
    else if (sel < 65) return {6'b000100, a, b, 16'($urandom)};
    else if (sel < 98) return {6'b000000, a, b, d, 5'($urandom), 6'($urandom_range(0, 2))};
    else if (sel < 99) return {6'b111111, a, b, 16'($urandom)};
    else               return {6'b000000, a, b, d, 5'd0, 6'b000011};
  endfunction

  initial begin
    logic [31:0] ins;
    logic        v, f, we;
    reset = 1'b1; instr_in = 32'd0; instr_valid = 1'b0; flush = 1'b0;
    wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
    model_reset();
    do_reset();

    // R-type ADD with preloaded sources
    step(32'd0, 1'b0, 1'b0, 1'b1, 5'd2, 32'd5);
    step(32'd0, 1'b0, 1'b0, 1'b1, 5'd3, 32'd7);
    step(32'h00430800, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    check("add.rs", rs, 32'd5);
    check("add.rt", rt, 32'd7);
    check("add.aluop", {30'd0, ALUOp}, 32'd2);
    check("add.dest", {27'd0, dest_reg}, 32'd1);
    check("add.funct", {26'd0, sign_ext[5:0]}, 32'd0);

    // Forwarding on addi r4,r2,-4 while r2 is written back; r0 write ignored
    step(32'h2044FFFC, 1'b1, 1'b0, 1'b1, 5'd2, 32'h10);
    check("fwd.rs", rs, 32'h10);
    check("fwd.sign_ext", sign_ext, 32'hFFFFFFFC);
    check("fwd.alusrc", {31'd0, ALUSrc}, 32'd1);
    step(32'd0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h55);
    step(32'h20080000, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    check("r0.rs", rs, 32'd0);

    // Load-use: lw r5 then add r6,r5,r5 (one bubble, then issue)
    step(32'h8C250000, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    step(32'h00A53000, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    check("lu.bubble", {31'd0, stall_flag_ex}, 32'd1);
    step(32'h00A53000, 1'b1, 1'b0, 1'b1, 5'd5, 32'hABCD);
    check("lu.issue", {31'd0, stall_flag_ex}, 32'd0);
    check("lu.rs_fwd", rs, 32'hABCD);

    // lw r5 then addi r6,r7,1: rt is a destination, no stall
    step(32'h8C250000, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    step(32'h20E60001, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    check("nolu.issue", {31'd0, stall_flag_ex}, 32'd0);

    // Flush beats a pending hazard; next instruction issues at once
    step(32'h8C250000, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    step(32'h00A53000, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
    check("flush.bubble", {31'd0, stall_flag_ex}, 32'd1);
    step(32'h20E60001, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    check("flush.issue", {31'd0, stall_flag_ex}, 32'd0);

    // Reset in the middle of a stall
    step(32'h8C250000, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    step(32'h00A53000, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    do_reset();
    step(32'h00A53000, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    check("rstmid.issue", {31'd0, stall_flag_ex}, 32'd0);
    for (int i = 1; i < 32; i++) begin
      step({6'd0, 5'(i), 5'(i), 5'd1, 5'd0, 6'd0}, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
      check("rst.regzero", rs, 32'd0);
    end

    // Illegal opcode and funct are sticky
    step(32'hFC000000, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    check("ill.op", {31'd0, illegal_instr}, 32'd1);
    check("ill.bubble", {31'd0, stall_flag_ex}, 32'd1);
    step(32'h00430803, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    check("ill.funct_bubble", {31'd0, stall_flag_ex}, 32'd1);
    step(32'h00430800, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    check("ill.sticky", {31'd0, illegal_instr}, 32'd1);

    // Randomized traffic, honouring hold_fetch by re-presenting the instruction
    do_reset();
    ins = 32'd0; v = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (!m_hz) begin
        ins = rand_instr();
        v   = ($urandom_range(0, 9) != 0);
      end
      f  = ($urandom_range(0, 9) == 0);
      we = $urandom_range(0, 1) == 1;
      step(ins, v, f, we, 5'($urandom_range(0, 7)), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage and ID/EX pipeline register for the 5-stage MIPS-subset pipeline.
- Reads the 32-entry register file, decodes control and sign-extends the immediate.
- Registers rs/rt/sign_ext/ALUSrc/ALUOp/branch plus a stall flag into the EX stage.
- Owns load-use hazard detection (one-cycle bubble, fetch hold) and taken-branch flush.

Parameters:
DATA_W, 32, register/operand width
RA_W, 5, register address width (2^RA_W registers)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
instr_in  in  32  instruction from IF/ID
instr_valid  in  1  instr_in holds a real instruction
flush  in  1  branch taken in EX this cycle; squash current decode
wb_en  in  1  writeback enable
wb_addr  in  5  writeback register
wb_data  in  32  writeback data
rs  out  32  registered rs operand
rt  out  32  registered rt operand
sign_ext  out  32  registered sign-extended instr[15:0]; [5:0] is funct for R-type
ALUSrc  out  1  0=rt, 1=sign_ext
ALUOp  out  2  00 lw/sw/addi, 01 beq, 10 R-type
branch  out  1  beq in EX
mem_read  out  1  lw in EX
mem_write  out  1  sw in EX
reg_write  out  1  EX instruction writes a register
dest_reg  out  5  destination register
stall_flag_ex  out  1  1 = bubble in ID/EX; EX must not update
hold_fetch  out  1  combinational; IF/ID must hold instr_in this cycle
illegal_instr  out  1  sticky; unsupported opcode/funct seen

Behaviour:
- Reset (async): every output register 0 except stall_flag_ex=1; illegal_instr=0; all 32 registers=0; FSM=RUN. hold_fetch=0 while reset is asserted.
- Opcodes: R=000000, lw=100011, sw=101011, addi=001000, beq=000100.
- R-type funct: ADD=000000, MUL=000001, SUB=000010.
- Decode fields: rs=[25:21], rt=[20:16], rd=[15:11], imm=[15:0]; sign_ext={{16{imm[15]}},imm}.
- Control by instruction:
  - R: ALUSrc0 ALUOp10 reg_write dest=rd.
  - lw: ALUSrc1 ALUOp00 mem_read reg_write dest=rt.
  - sw: ALUSrc1 ALUOp00 mem_write dest=0.
  - addi: ALUSrc1 ALUOp00 reg_write dest=rt.
  - beq: ALUSrc0 ALUOp01 branch dest=0.
- Register file:
  - Write at posedge when wb_en and wb_addr!=0. Writes to r0 are ignored; r0 always reads 0.
  - Read is write-through: if wb_en and wb_addr==read addr and addr!=0, wb_data is forwarded to the operand in the same cycle.
- Latency: one cycle. The instruction presented at edge N appears on the ID/EX outputs after edge N.
- Bubble load (all controls 0, dest_reg 0, stall_flag_ex=1; rs/rt/sign_ext may update) occurs when any of:
  - flush;
  - !instr_valid;
  - an illegal opcode or funct (also sets illegal_instr);
  - a load-use stall.
- Otherwise the outputs are loaded with the decode result and stall_flag_ex=0.
- Load-use hazard (combinational): all of the following hold:
  - FSM=RUN and instr_valid and !flush;
  - ID/EX holds mem_read=1 with dest_reg!=0;
  - dest_reg==instr rs, OR (dest_reg==instr rt and the instruction is R, sw or beq).
- FSM:
  - RUN: on a hazard, assert hold_fetch, load a bubble, go to STALL. Otherwise load normally and stay in RUN.
  - STALL: decode the held instr_in normally (no hazard check), hold_fetch=0, go to RUN.
  - flush in either state: load a bubble, hold_fetch=0, go to RUN. flush has priority over a hazard.
- Writeback and decode of the same register in one cycle use the forwarded value. This applies in both RUN and STALL.
- Reset mid-stall: return immediately to RUN with bubble outputs.

Test Plan:
- Reset: assert reset. Expect stall_flag_ex=1, all controls 0, hold_fetch=0; r1..r31 read 0 afterwards.
- R-type ADD: preload r2=5, r3=7, then issue add r1,r2,r3 (0x00430800 with funct 000000). Next cycle expect rs=5, rt=7, ALUOp=10, ALUSrc=0, reg_write=1, dest_reg=1, sign_ext[5:0]=0, stall_flag_ex=0.
- Forwarding and r0: same cycle as decode of addi r4,r2,-4, wb r2=0x10. Expect rs=0x10, sign_ext=0xFFFFFFFC, ALUSrc=1. Then wb r0=0x55. Expect a later read of r0 = 0.
- Load-use stall: lw r5,0(r1) followed by add r6,r5,r5.
  - Cycle after lw: hold_fetch=1 and ID/EX becomes a bubble (stall_flag_ex=1).
  - Next cycle: add issues with stall_flag_ex=0 and hold_fetch=0.
  - lw r5 followed by addi r6,r7,1 (rt not used as a source): no stall.
- Flush priority: hazard condition present plus flush=1. Expect a bubble, hold_fetch=0, FSM RUN (next hazard-free instruction issues in one cycle).
- Illegal: opcode 111111 or R-type funct 000011. Expect a bubble, illegal_instr=1, remaining 1 until reset.
